// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: hold levels, FSM states, reset vector.
package pipe_ctrl_pkg;

    localparam int HOLD_W = 3;

    localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] CPU_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl.sv
// Fixed-priority redirect/stall arbiter driving the PC register, with post-redirect flush sequencing.
// Zero-cycle combinational redirect; bus/EX/JTAG stalls are reflected on hold_flag_o.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_jump_req_i,
    input  logic [ADDR_W-1:0] ex_jump_addr_i,
    input  logic              ex_hold_req_i,
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic              trap_ack_o,
    input  logic              bus_hold_req_i,
    input  logic              jtag_halt_req_i,
    output logic              jtag_halted_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic [HOLD_W-1:0] hold_flag_o,
    output logic              flush_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    state_t              state_q, state_d;
    logic                pend_v_q, pend_v_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                redir;
    logic [ADDR_W-1:0]   redir_addr;

    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        cnt_d       = cnt_q;
        redir       = 1'b0;
        redir_addr  = '0;
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        hold_flag_o = HOLD_NONE;
        flush_o     = 1'b0;
        trap_ack_o  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus_hold_req_i) begin
                    hold_flag_o = HOLD_ID;
                    if (ex_jump_req_i) begin
                        pend_v_d    = 1'b1;
                        pend_addr_d = ex_jump_addr_i;
                    end
                end else if (trap_req_i) begin
                    redir      = 1'b1;
                    redir_addr = trap_addr_i;
                    trap_ack_o = 1'b1;
                    pend_v_d   = 1'b0;
                end else if (pend_v_q) begin
                    redir      = 1'b1;
                    redir_addr = pend_addr_q;
                    pend_v_d   = 1'b0;
                end else if (ex_jump_req_i) begin
                    redir      = 1'b1;
                    redir_addr = ex_jump_addr_i;
                end else if (jtag_halt_req_i) begin
                    hold_flag_o = HOLD_ID;
                    state_d     = ST_HALT;
                end else if (ex_hold_req_i) begin
                    hold_flag_o = HOLD_ID;
                end
            end

            // EX jumps are dropped here: the instruction that raised them was killed.
            ST_FLUSH: begin
                flush_o = 1'b1;
                if (bus_hold_req_i) begin
                    hold_flag_o = HOLD_ID;
                end else if (trap_req_i) begin
                    redir      = 1'b1;
                    redir_addr = trap_addr_i;
                    trap_ack_o = 1'b1;
                    pend_v_d   = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_HALT: begin
                hold_flag_o = HOLD_ID;
                if (ex_jump_req_i) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = ex_jump_addr_i;
                end
                if (!jtag_halt_req_i) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Jump and ID hold coexist; the PC register gives the jump precedence.
        if (redir) begin
            jump_flag_o = 1'b1;
            jump_addr_o = redir_addr;
            flush_o     = 1'b1;
            hold_flag_o = HOLD_ID;
            cnt_d       = CNT_INIT;
            state_d     = ST_FLUSH;
        end

        if (rst) begin
            jump_flag_o = 1'b0;
            jump_addr_o = '0;
            hold_flag_o = HOLD_NONE;
            flush_o     = 1'b0;
            trap_ack_o  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pend_v_q      <= 1'b0;
            pend_addr_q   <= ADDR_W'(CPU_RESET_ADDR);
            cnt_q         <= '0;
            jtag_halted_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_v_q      <= pend_v_d;
            pend_addr_q   <= pend_addr_d;
            cnt_q         <= cnt_d;
            jtag_halted_o <= (state_d == ST_HALT);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_pipe_ctrl;

    localparam int AW = 32;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_jump_req_i;
    logic [AW-1:0] ex_jump_addr_i;
    logic          ex_hold_req_i;
    logic          trap_req_i;
    logic [AW-1:0] trap_addr_i;
    logic          trap_ack_o;
    logic          bus_hold_req_i;
    logic          jtag_halt_req_i;
    logic          jtag_halted_o;
    logic          jump_flag_o;
    logic [AW-1:0] jump_addr_o;
    logic [2:0]    hold_flag_o;
    logic          flush_o;

    always #5 clk = ~clk;

    pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_jump_req_i  (ex_jump_req_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .ex_hold_req_i  (ex_hold_req_i),
        .trap_req_i     (trap_req_i),
        .trap_addr_i    (trap_addr_i),
        .trap_ack_o     (trap_ack_o),
        .bus_hold_req_i (bus_hold_req_i),
        .jtag_halt_req_i(jtag_halt_req_i),
        .jtag_halted_o  (jtag_halted_o),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .hold_flag_o    (hold_flag_o),
        .flush_o        (flush_o)
    );

    typedef struct packed {
        logic          jf;
        logic [AW-1:0] ja;
        logic [2:0]    hold;
        logic          flush;
        logic          ack;
        logic          halted;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } sb_t;

    typedef enum {M_RUN, M_FLUSH, M_HALT} mmode_t;

    sb_t           sb_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    // Reference model: mode, bubbles still owed, and at most one buffered jump target.
    mmode_t        m_mode = M_RUN;
    int            m_left = 0;
    logic [AW-1:0] m_pend[$];
    logic          trap_pend = 1'b0;
    logic [AW-1:0] trap_vec = '0;

    task automatic redirect(inout obs_t e, input logic [AW-1:0] a);
        e.jf    = 1'b1;
        e.ja    = a;
        e.flush = 1'b1;
        e.hold  = 3'd3;
        m_mode  = M_FLUSH;
        m_left  = FC;
    endtask

    task automatic model_cycle(output obs_t e);
        e = '0;
        if (rst) begin
            m_mode = M_RUN;
            m_left = 0;
            m_pend.delete();
            return;
        end
        e.halted = (m_mode == M_HALT);
        case (m_mode)
            M_RUN: begin
                if (bus_hold_req_i) begin
                    e.hold = 3'd3;
                    if (ex_jump_req_i) begin
                        m_pend.delete();
                        m_pend.push_back(ex_jump_addr_i);
                    end
                end else if (trap_req_i) begin
                    m_pend.delete();
                    e.ack = 1'b1;
                    redirect(e, trap_addr_i);
                end else if (m_pend.size() != 0) begin
                    redirect(e, m_pend.pop_front());
                end else if (ex_jump_req_i) begin
                    redirect(e, ex_jump_addr_i);
                end else if (jtag_halt_req_i) begin
                    e.hold = 3'd3;
                    m_mode = M_HALT;
                end else if (ex_hold_req_i) begin
                    e.hold = 3'd3;
                end
            end
            M_FLUSH: begin
                e.flush = 1'b1;
                if (bus_hold_req_i) begin
                    e.hold = 3'd3;
                end else if (trap_req_i) begin
                    m_pend.delete();
                    e.ack = 1'b1;
                    redirect(e, trap_addr_i);
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_RUN;
                end
            end
            default: begin
                e.hold = 3'd3;
                if (ex_jump_req_i) begin
                    m_pend.delete();
                    m_pend.push_back(ex_jump_addr_i);
                end
                if (!jtag_halt_req_i) m_mode = M_RUN;
            end
        endcase
    endtask

    // One core cycle: drive inputs just after the edge, predict outputs, queue the prediction.
    task automatic cycle(input logic r, input logic bus, input logic exj, input logic [AW-1:0] ja,
                         input logic exh, input logic jtag, input logic rt, input logic [AW-1:0] tv);
        obs_t e;
        @(posedge clk);
        #1;
        if (rt && !trap_pend) trap_vec = tv;
        rst             = r;
        bus_hold_req_i  = bus;
        ex_jump_req_i   = exj;
        ex_jump_addr_i  = ja;
        ex_hold_req_i   = exh;
        jtag_halt_req_i = jtag;
        trap_req_i      = (trap_pend | rt) & ~r;
        trap_addr_i     = trap_vec;
        model_cycle(e);
        trap_pend = trap_req_i & ~e.ack;
        sb_q.push_back('{cyc, e});
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        forever begin
            sb_t  s;
            obs_t a;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                s = sb_q.pop_front();
                a = {jump_flag_o, jump_addr_o, hold_flag_o, flush_o, trap_ack_o, jtag_halted_o};
                total++;
                if (a !== s.o) begin
                    bad++;
                    $display("FAIL outputs cyc%0d: got jf=%b ja=%h hold=%0d flush=%b ack=%b halted=%b, want jf=%b ja=%h hold=%0d flush=%b ack=%b halted=%b",
                             s.cyc, a.jf, a.ja, a.hold, a.flush, a.ack, a.halted,
                             s.o.jf, s.o.ja, s.o.hold, s.o.flush, s.o.ack, s.o.halted);
                end
            end
        end
    end

    initial begin
        logic jtag_lvl;
        rst             = 1'b1;
        bus_hold_req_i  = 1'b0;
        ex_jump_req_i   = 1'b0;
        ex_jump_addr_i  = '0;
        ex_hold_req_i   = 1'b0;
        jtag_halt_req_i = 1'b0;
        trap_req_i      = 1'b0;
        trap_addr_i     = '0;

        // Reset with activity on inputs: outputs must stay zero.
        cycle(1'b1, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 1'b0, 1'b1, 32'h0000_0080);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        idle(2);

        // EX jump in RUN, then flush bubbles.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, '0);
        idle(4);

        // Trap and EX jump together: trap wins.
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
        idle(4);

        // Bus stall buffers the EX jump, issued on release.
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        idle(5);

        // Same, with a trap arriving during the stall: pending jump discarded.
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        idle(6);

        // JTAG halt with a trap raised while halted.
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
        idle(6);

        // Reset with a buffered jump, then reset mid-flush; neither leaves stale state.
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        idle(3);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, '0);
        idle(4);

        // Random traffic.
        jtag_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) jtag_lvl = ~jtag_lvl;
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  AW'($urandom),
                  $urandom_range(0, 4) == 0,
                  jtag_lvl,
                  $urandom_range(0, 14) == 0,
                  AW'($urandom));
        end
        idle(1);

        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d predictions left unchecked, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
